uart_status_tx: RTL and testbench
=================================

Name: uart_status_tx

Overview:
Transmit-side companion to the UART command parser. It formats a status word as an ASCII line and streams it byte by byte into the UART core's AXI-stream TX input. The same path as the parser's replies feeds the same uart TX port, and the two are merged by an upstream arbiter outside this block. A frame is sent on a request pulse, or on an optional periodic tick.

Parameters:
DATA_WIDTH, 32, status word width; must be a multiple of 4 and at least 4.
PERIOD_CYCLES, 0, auto-report period in clk cycles; 0 disables the periodic tick.
TAG, 8'h53, first byte of every frame (ASCII 'S').

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  synchronous reset, active-low
report_req  in  1  single-cycle request to send one frame
status_data  in  DATA_WIDTH  status word to report
m_axis_tdata  out  8  byte to the uart TX AXI-stream input
m_axis_tvalid  out  1  byte valid
m_axis_tready  in  1  uart TX ready
busy  out  1  high while a frame is in flight
req_merged  out  1  one-cycle pulse when a request is absorbed into an already pending request

Behaviour:
- Frame format: TAG, ':' (0x3A), then DATA_WIDTH/4 uppercase hex digits MSB nibble first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46), then CR (0x0D), then LF (0x0A).
  - Frame length is NB = DATA_WIDTH/4 + 4 bytes; for the default, NB = 12.
- Reset values (rst_n = 0 sampled at a clk edge): m_axis_tvalid = 0, m_axis_tdata = 0, busy = 0, req_merged = 0, pending = 0, timer = 0, byte index = 0, state = IDLE.
- Reset mid-frame: the frame is abandoned with no completion. tvalid is low after the reset edge, and the first byte after reset is a fresh TAG.
- Start trigger: trig = report_req | tick | pending.
  - tick pulses one cycle when the timer reaches PERIOD_CYCLES-1; the timer then wraps to 0.
  - The timer runs continuously and is not gated by busy.
- State IDLE: when trig is high, capture status_data into the shift register, clear pending, and go to SEND with byte index 0.
  - m_axis_tvalid = 1 with tdata = TAG on the next cycle (1-cycle latency from report_req).
- State SEND: tvalid is held high.
  - tdata is selected by the byte index: 0 is TAG, 1 is ':', 2..NB-3 are hex digits, NB-2 is CR, NB-1 is LF.
  - A hex digit comes from the top nibble of the shift register; the register shifts left by 4 on each accepted hex byte.
  - On a handshake (tvalid & tready), the index increments.
  - On the handshake of byte NB-1: go to IDLE, tvalid = 0 on the next cycle, busy = 0.
- AXI rules:
  - tdata and tvalid are registered.
  - While tvalid = 1 and tready = 0, tdata and tvalid stay stable indefinitely.
  - tvalid never depends combinationally on tready.
- busy = (state == SEND).
- Request while busy (report_req or tick):
  - If pending = 0, set pending = 1.
  - If pending = 1 already, pulse req_merged on the next cycle; at most one frame is queued.
- Pending frame: starts from IDLE, giving exactly one idle cycle (tvalid = 0) between frames. Its status_data is sampled at frame start, not at request time.
- report_req and tick in the same cycle count as one request (no req_merged pulse).
- A request arriving in the same cycle as the final LF handshake sets pending and produces one further frame.
- The status snapshot is fixed for the duration of a frame; changes on status_data during SEND have no effect.

Decomposition:
- Package uart_pkg holds:
  - ASCII constants: ASCII_COLON, ASCII_CR, ASCII_LF, ASCII_0, ASCII_A.
  - Function nibble_to_ascii(4-bit) returning 8 bits.
  - State encoding constants ST_IDLE and ST_SEND.
- Sub-module uart_period_timer (counter plus tick output, fixed 0 when PERIOD_CYCLES = 0) is instantiated once.
- No other sub-modules.

Test Plan:
- Default parameters, tready tied 1, report_req pulse with status_data = 32'hDEADBEEF
  -> bytes 53 3A 44 45 41 44 42 45 45 46 0D 0A on 12 consecutive cycles, first byte 1 cycle after req, busy high for exactly 12 cycles.
- status_data = 32'h0123ABCD, tready toggled pseudo-randomly with 5-cycle stalls
  -> same byte order (53 3A 30 31 32 33 41 42 43 44 0D 0A); tdata stable during every stall; no byte duplicated or dropped.
- Three report_req pulses during one frame
  -> exactly two frames total; one req_merged pulse on the third request; exactly one tvalid-low cycle between frames; second frame carries status_data at its start.
- PERIOD_CYCLES = 2000, no report_req
  -> frames start every 2000 cycles; report_req coincident with a tick yields a single frame.
- rst_n = 0 asserted at byte index 5 with tready = 1
  -> tvalid = 0 the cycle after the reset edge, busy = 0, pending cleared; next report_req yields a full frame starting with 0x53.
- DATA_WIDTH = 8, status_data = 8'h0F
  -> bytes 53 3A 30 46 0D 0A (6 bytes).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and the nibble-to-ASCII helper for the UART status
// transmitter.
package uart_pkg;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Uppercase hex digit for a 4-bit value.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [3:0] above_nine;
    above_nine = nib - 4'd10;
    if (nib < 4'd10) begin
      return ASCII_0 + {4'h0, nib};
    end
    return ASCII_A + {4'h0, above_nine};
  endfunction

endpackage

// File: rtl/uart_period_timer.sv
// Free-running period counter; tick pulses on the last count of each period.
// With PERIOD_CYCLES = 0 the counter is held at zero and tick never fires.
module uart_period_timer #(
  parameter int unsigned PERIOD_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam bit          ENABLED = (PERIOD_CYCLES != 0);
  localparam int unsigned CW      = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST  = CW'(ENABLED ? PERIOD_CYCLES - 1 : 0);

  logic [CW-1:0] timer_q;
  logic          at_last;

  assign at_last = (timer_q == LAST);
  assign tick    = ENABLED && at_last;

  always_ff @(posedge clk) begin
    if (!rst_n || !ENABLED || at_last) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_status_tx.sv
// Formats a status word as "<TAG>:<hex digits>\r\n" and streams it byte by byte
// into an AXI-stream byte sink, on request or on a periodic tick.
module uart_status_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PERIOD_CYCLES = 0,
  parameter logic [7:0]  TAG           = 8'h53
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  report_req,
  input  logic [DATA_WIDTH-1:0] status_data,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  req_merged
);

  localparam int unsigned NB = DATA_WIDTH / 4 + 4;
  localparam int unsigned IW = $clog2(NB);

  localparam logic [IW-1:0] IDX_COLON     = IW'(1);
  localparam logic [IW-1:0] IDX_HEX_FIRST = IW'(2);
  localparam logic [IW-1:0] IDX_HEX_LAST  = IW'(NB - 3);
  localparam logic [IW-1:0] IDX_CR        = IW'(NB - 2);
  localparam logic [IW-1:0] IDX_LF        = IW'(NB - 1);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [IW-1:0]         idx_q;
  logic                  pending_q;

  logic                  tick;
  logic                  req;
  logic                  trig;
  logic                  hs;
  logic                  hex_acc;
  logic [IW-1:0]         idx_nxt;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [7:0]            byte_nxt;

  uart_period_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // A request and a tick in the same cycle collapse into one request.
  assign req     = report_req | tick;
  assign trig    = req | pending_q;
  assign hs      = m_axis_tvalid & m_axis_tready;
  assign hex_acc = (idx_q >= IDX_HEX_FIRST) && (idx_q <= IDX_HEX_LAST);
  assign busy    = (state_q == ST_SEND);

  // Byte that follows the one currently presented, prepared for the handshake edge.
  always_comb begin
    idx_nxt   = idx_q + 1'b1;
    shreg_nxt = hex_acc ? (shreg_q << 4) : shreg_q;
    byte_nxt  = nibble_to_ascii(shreg_nxt[DATA_WIDTH-1 -: 4]);
    if (idx_nxt == IDX_COLON) begin
      byte_nxt = ASCII_COLON;
    end else if (idx_nxt == IDX_CR) begin
      byte_nxt = ASCII_CR;
    end else if (idx_nxt == IDX_LF) begin
      byte_nxt = ASCII_LF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      req_merged    <= 1'b0;
    end else begin
      req_merged <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (trig) begin
            state_q       <= ST_SEND;
            shreg_q       <= status_data;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= TAG;
          end
        end
        ST_SEND: begin
          // At most one frame is queued behind the one in flight.
          if (req) begin
            if (pending_q) begin
              req_merged <= 1'b1;
            end else begin
              pending_q <= 1'b1;
            end
          end
          if (hs) begin
            if (idx_q == IDX_LF) begin
              state_q       <= ST_IDLE;
              idx_q         <= '0;
              m_axis_tvalid <= 1'b0;
              m_axis_tdata  <= '0;
            end else begin
              idx_q        <= idx_nxt;
              shreg_q      <= shreg_nxt;
              m_axis_tdata <= byte_nxt;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_status_tx.sv
// Directed bench for uart_status_tx: default, periodic (2000) and 8-bit instances.
module tb_uart_status_tx;

  typedef struct {
    logic [31:0] sd;
    bit          stall;
    logic [7:0]  bytes [12];
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_na;

  logic        report_req_a, tready_a, tvalid_a, busy_a, merged_a;
  logic [31:0] status_a;
  logic [7:0]  tdata_a;

  logic        report_req_b, tready_b, tvalid_b, busy_b, merged_b;
  logic [31:0] status_b;
  logic [7:0]  tdata_b;

  logic        report_req_c, tready_c, tvalid_c, busy_c, merged_c;
  logic [7:0]  status_c;
  logic [7:0]  tdata_c;

  uart_status_tx u_dut_a (
    .clk(clk), .rst_n(rst_na), .report_req(report_req_a), .status_data(status_a),
    .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a),
    .busy(busy_a), .req_merged(merged_a)
  );

  uart_status_tx #(.DATA_WIDTH(32), .PERIOD_CYCLES(2000)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .report_req(report_req_b), .status_data(status_b),
    .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
    .busy(busy_b), .req_merged(merged_b)
  );

  uart_status_tx #(.DATA_WIDTH(8)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .report_req(report_req_c), .status_data(status_c),
    .m_axis_tdata(tdata_c), .m_axis_tvalid(tvalid_c), .m_axis_tready(tready_c),
    .busy(busy_c), .req_merged(merged_c)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame-start log for the periodic instance.
  int   starts_b[$];
  int   merges_b = 0;
  logic prev_v_b = 1'b0;
  always @(negedge clk) begin
    if (tvalid_b && !prev_v_b) starts_b.push_back(cyc);
    if (merged_b) merges_b++;
    prev_v_b = tvalid_b;
  end

  logic [7:0] got_q[$];
  int         hs_q[$];
  int         merges_a;
  vec_t       vecs[3];
  logic [7:0] exp_c [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int         k = 0;
    int         busy_n = 0;
    int         t = 0;
    int         stall_left = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_d = '0;
    @(posedge clk); #1;
    report_req_a = 1'b1; status_a = v.sd; tready_a = 1'b1;
    @(negedge clk);
    check("pre_valid", {31'b0, tvalid_a}, 32'd0);
    @(posedge clk); #1;
    report_req_a = 1'b0;
    status_a = ~v.sd;
    while (k < 12 && t < 300) begin
      if (v.stall && stall_left > 0) begin
        stall_left--; tready_a = 1'b0;
      end else if (v.stall && $urandom_range(0, 2) == 0) begin
        stall_left = 4; tready_a = 1'b0;
      end else begin
        tready_a = 1'b1;
      end
      @(negedge clk);
      if (t == 0) check("latency_valid", {31'b0, tvalid_a}, 32'd1);
      check("valid_held", {31'b0, tvalid_a}, 32'd1);
      if (busy_a) busy_n++;
      if (prev_stall) check("stall_stable", {24'b0, tdata_a}, {24'b0, prev_d});
      if (tvalid_a && tready_a) begin
        check("frame_byte", {24'b0, tdata_a}, {24'b0, v.bytes[k]});
        k++;
      end
      prev_stall = tvalid_a && !tready_a;
      prev_d     = tdata_a;
      t++;
      @(posedge clk); #1;
    end
    check("frame_len", k, 12);
    tready_a = 1'b1;
    @(negedge clk);
    check("post_valid", {31'b0, tvalid_a}, 32'd0);
    check("post_busy", {31'b0, busy_a}, 32'd0);
    if (!v.stall) check("busy_cycles", busy_n, 12);
  endtask

  task automatic run_script(input int r0, input int r1, input int r2, input int sw,
                            input logic [31:0] sd1, input logic [31:0] sd2, input int n);
    got_q.delete(); hs_q.delete(); merges_a = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      report_req_a = (i == r0) || (i == r1) || (i == r2);
      status_a     = (i < sw) ? sd1 : sd2;
      tready_a     = 1'b1;
      @(negedge clk);
      if (tvalid_a && tready_a) begin
        got_q.push_back(tdata_a);
        hs_q.push_back(i);
      end
      if (merged_a) merges_a++;
    end
    report_req_a = 1'b0;
  endtask

  task automatic check_script(input vec_t f1, input vec_t f2, input int want_merges);
    logic [7:0] want, got;
    check("script_bytes", got_q.size(), 24);
    for (int k = 0; k < 24; k++) begin
      want = (k < 12) ? f1.bytes[k] : f2.bytes[k - 12];
      got  = (k < got_q.size()) ? got_q[k] : 8'hxx;
      check("script_byte", {24'b0, got}, {24'b0, want});
    end
    if (hs_q.size() >= 13) check("idle_gap", hs_q[12] - hs_q[11], 2);
    check("merges", merges_a, want_merges);
  endtask

  initial begin
    int k, t, stray, s, in_win;
    rst_n = 1'b0; rst_na = 1'b0;
    report_req_a = 1'b0; status_a = '0; tready_a = 1'b1;
    report_req_b = 1'b0; status_b = 32'h1234_5678; tready_b = 1'b1;
    report_req_c = 1'b0; status_c = '0; tready_c = 1'b1;

    vecs[0] = '{sd: 32'hDEADBEEF, stall: 1'b0, bytes: '{8'h53, 8'h3A, 8'h44, 8'h45, 8'h41, 8'h44,
                8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A}};
    vecs[1] = '{sd: 32'h0123ABCD, stall: 1'b1, bytes: '{8'h53, 8'h3A, 8'h30, 8'h31, 8'h32, 8'h33,
                8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A}};
    vecs[2] = '{sd: 32'h9A5F0C71, stall: 1'b0, bytes: '{8'h53, 8'h3A, 8'h39, 8'h41, 8'h35, 8'h46,
                8'h30, 8'h43, 8'h37, 8'h31, 8'h0D, 8'h0A}};
    exp_c = '{8'h53, 8'h3A, 8'h30, 8'h46, 8'h0D, 8'h0A};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, tvalid_a}, 32'd0);
    check("rst_data", {24'b0, tdata_a}, 32'd0);
    check("rst_busy", {31'b0, busy_a}, 32'd0);
    check("rst_merged", {31'b0, merged_a}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; rst_na = 1'b1;

    for (int i = 0; i < 3; i++) run_frame(vecs[i]);

    // Start + two requests in flight: one queued, one merged; queued frame samples late data.
    run_script(0, 3, 6, 8, 32'hDEADBEEF, 32'h0123ABCD, 40);
    check_script(vecs[0], vecs[1], 1);
    // Request coincident with the final LF handshake.
    run_script(0, 12, -1, 5, 32'hDEADBEEF, 32'h9A5F0C71, 40);
    check_script(vecs[0], vecs[2], 0);

    // Reset while byte 5 is presented, with a frame already queued.
    @(posedge clk); #1; report_req_a = 1'b1; status_a = 32'hDEADBEEF; tready_a = 1'b1;
    @(posedge clk); #1; report_req_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; report_req_a = 1'b1;
    @(posedge clk); #1; report_req_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst_na = 1'b0;
    @(negedge clk);
    check("rst_mid_byte5", {24'b0, tdata_a}, 32'h44);
    @(posedge clk); #1; rst_na = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", {31'b0, tvalid_a}, 32'd0);
    check("rst_mid_busy", {31'b0, busy_a}, 32'd0);
    check("rst_mid_data", {24'b0, tdata_a}, 32'd0);
    stray = 0;
    repeat (10) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (tvalid_a || busy_a) stray++;
    end
    check("rst_pending_clear", stray, 0);
    run_frame(vecs[2]);

    // 8-bit instance.
    @(posedge clk); #1; report_req_c = 1'b1; status_c = 8'h0F;
    @(posedge clk); #1; report_req_c = 1'b0; status_c = 8'hA5;
    k = 0; t = 0;
    while (k < 6 && t < 50) begin
      @(negedge clk);
      if (tvalid_c && tready_c) begin
        check("c_byte", {24'b0, tdata_c}, {24'b0, exp_c[k]});
        k++;
      end
      t++;
      @(posedge clk); #1;
    end
    check("c_len", k, 6);
    @(negedge clk);
    check("c_done_valid", {31'b0, tvalid_c}, 32'd0);

    // Periodic instance.
    while (starts_b.size() < 3 && cyc < 12000) @(posedge clk);
    #1;
    check("b_three_starts", {31'b0, starts_b.size() >= 3}, 32'd1);
    if (starts_b.size() >= 3) begin
      check("b_period1", starts_b[1] - starts_b[0], 2000);
      check("b_period2", starts_b[2] - starts_b[1], 2000);
      s = starts_b[2] + 2000;
      while (cyc < s - 1) begin
        @(posedge clk); #1;
      end
      report_req_b = 1'b1;
      @(posedge clk); #1;
      report_req_b = 1'b0;
      while (cyc < s + 2100) begin
        @(posedge clk); #1;
      end
      in_win = 0;
      foreach (starts_b[i]) if (starts_b[i] > s - 1 && starts_b[i] < s + 2000) in_win++;
      check("b_coincident_single", in_win, 1);
      check("b_start_at_tick", starts_b[3], s);
      check("b_next_period", starts_b[4], s + 2000);
      check("b_no_merge", merges_b, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
